// File: rtl/sll_seq.sv
// Sequential logical left shifter: resolves one shift-amount bit per cycle
// (weights 1,2,4,8,16) and flags signed overflow, behind a start/ready handshake.
module sll_seq #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ctrl_shift,
    input  logic [WIDTH-1:0]   data_operand,
    input  logic [SHAMT_W-1:0] ctrl_shamt,
    output logic [WIDTH-1:0]   data_result,
    output logic               data_resultRDY,
    output logic               data_exception,
    output logic               data_busy
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [2:0] LAST_STAGE = 3'(SHAMT_W - 1);

    state_t             state_q, state_d;
    logic [2:0]         stage_q, stage_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [SHAMT_W-1:0] shamt_q, shamt_d;
    logic               ovf_q, ovf_d;
    logic               exc_q, exc_d;

    logic [SHAMT_W:0]   stepAmt;
    logic [WIDTH-1:0]   edgeDiff;
    logic [WIDTH-1:0]   windowMask;
    logic [WIDTH-1:0]   shiftedWork;
    logic               stageOvf;

    // A stage overflows when the top stepAmt+1 bits are not uniform: any
    // adjacent-bit difference inside the top stepAmt positions reveals it.
    always_comb begin
        stepAmt     = {{SHAMT_W{1'b0}}, 1'b1} << stage_q;
        edgeDiff    = work_q ^ (work_q << 1);
        windowMask  = ~({WIDTH{1'b1}} >> stepAmt);
        stageOvf    = |(edgeDiff & windowMask);
        shiftedWork = work_q << stepAmt;
    end

    always_comb begin
        state_d  = state_q;
        stage_d  = stage_q;
        work_d   = work_q;
        shamt_d  = shamt_q;
        ovf_d    = ovf_q;
        result_d = result_q;
        exc_d    = exc_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (ctrl_shift) begin
                    work_d  = data_operand;
                    shamt_d = ctrl_shamt;
                    stage_d = 3'd0;
                    ovf_d   = 1'b0;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (shamt_q[stage_q]) begin
                    work_d = shiftedWork;
                    ovf_d  = ovf_q | stageOvf;
                end
                stage_d = stage_q + 3'd1;
                if (stage_q == LAST_STAGE) begin
                    state_d  = DONE;
                    result_d = work_d;
                    exc_d    = ovf_d;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            stage_q  <= 3'd0;
            work_q   <= '0;
            shamt_q  <= '0;
            ovf_q    <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            stage_q  <= stage_d;
            work_q   <= work_d;
            shamt_q  <= shamt_d;
            ovf_q    <= ovf_d;
            result_q <= result_d;
            exc_q    <= exc_d;
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = (state_q == DONE);
    assign data_busy      = (state_q == SHIFT);

endmodule
